studio_keypad: RTL and testbench
================================

STUDIO_KEYPAD -- requirements
Module: studio_keypad

Interface
REQ-001 Parameter NUM_PADS, default 2, number of keypads decoded (legal 1..2).
REQ-002 Parameter DEB_CYCLES, default 50000, debounce sample period in clk cycles (legal 2..65535).
REQ-003 Port clk  input  1  sole clock, all state on rising edge.
REQ-004 Port resetq  input  1  asynchronous active-low reset.
REQ-005 Port ps2_key  input  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-006 Port io_n  input  3  CPU N2..N0 lines.
REQ-007 Port io_out  input  1  CPU OUT strobe, one cycle.
REQ-008 Port io_dout  input  8  CPU OUT data.
REQ-009 Port ef_n  output  2  [0]=EF3 pad 0, [1]=EF4 pad 1; active-low key-match flags.
REQ-010 Port key_code  output  8  lowest held pad-0 key 0..9, 8'hFF if none.
REQ-011 Port key_any  output  1  any debounced key held on any enabled pad.
REQ-012 Port key_sel  output  4  current key-select latch.

Function
REQ-013 Event detect: a change of ps2_key[10] versus its registered copy is one event; first clk after reset only loads the copy, no event.
REQ-014 Events with ps2_key[8]=1 or unmapped scancode are ignored.
REQ-015 Pad 0 map: 45,16,1E,26,25,2E,36,3D,3E,46 = keys 0..9 (main-row digits).
REQ-016 Pad 1 map: 70,69,72,7A,6B,73,74,6C,75,7D = keys 0..9 (numeric keypad); ignored when NUM_PADS=1.
REQ-017 Raw bitmap raw[p][k]: set on event with pressed=1, cleared with pressed=0; multiple keys may be held; applied cycle after event.
REQ-018 Select latch: io_out=1 and io_n=3'd2 loads key_sel <= io_dout[3:0] next cycle; other io_n values ignored.
REQ-019 ef_n[p] registered: 0 iff p<NUM_PADS, key_sel<=9, deb[p][key_sel]=1; else 1; one cycle after deb or key_sel change.
REQ-020 key_code, key_any registered from deb, one-cycle latency; lowest index wins on multiple keys.
REQ-021 Simultaneous scancode event and select OUT in one cycle: both take effect; no priority loss.
REQ-022 key_sel values 10..15 latch normally; ef_n forced 2'b11 while selected.
REQ-023 Break for a key not held: no effect; repeated make (typematic) for held key: no effect.

Reset
REQ-024 resetq low asynchronously clears raw, deb, sample history, prescaler, key_sel=0, ef_n=2'b11, key_code=8'hFF, key_any=0.
REQ-025 Reset mid-debounce or mid-keypress discards all state; held keys need a fresh make after release of reset.

Configuration
REQ-026 Macro STUDIO_KEYPAD_DEBOUNCE_EN defined: prescaler counts 0..DEB_CYCLES-1; on wrap, per key deb <= raw if raw equals previous tick sample, else deb holds; sample <= raw.
REQ-027 Debounce visibility: change stable across two ticks reaches deb within DEB_CYCLES+1 to 2*DEB_CYCLES+1 cycles after raw update.
REQ-028 Macro undefined: deb = raw combinationally, no prescaler/sample logic instantiated, DEB_CYCLES unused.

Verification
REQ-029 Macro off; OUT io_n=2 data 8'h05; event make 2E -> key_sel=5 then ef_n=2'b10 two cycles after event; break 2E -> ef_n=2'b11.
REQ-030 Macro off; make 74 (pad1 key6), select 6 -> ef_n=2'b01; NUM_PADS=1 same stimulus -> ef_n=2'b11, key_any=0.
REQ-031 Macro off; make 3E then 16 -> key_code 8'h08 then 8'h01; break 16 -> 8'h08; break 3E -> 8'hFF.
REQ-032 Macro on, DEB_CYCLES=4; make 1E, select 2 -> ef_n[0] falls within 5..9 cycles of raw update; make then break within 2 cycles -> ef_n stays 2'b11.
REQ-033 Select 8'h0C with key 0 held -> ef_n=2'b11; extended event E0 70 -> ignored.
REQ-034 resetq low while key held and key_sel=7 -> immediately ef_n=2'b11, key_sel=0, key_code=8'hFF; ps2_key[10]=1 at release -> no event.

Source files
------------

// File: rtl/studio_keypad_if.sv
// Bus between the PS/2 + CPU I/O side and the studio keypad decoder.
// Signal names match the board-level names used by the CPU glue logic.
interface studio_keypad_if;
  logic [10:0] ps2_key;
  logic [2:0]  io_n;
  logic        io_out;
  logic [7:0]  io_dout;
  logic [1:0]  ef_n;
  logic [7:0]  key_code;
  logic        key_any;
  logic [3:0]  key_sel;

  modport master (
    output ps2_key, io_n, io_out, io_dout,
    input  ef_n, key_code, key_any, key_sel
  );

  modport slave (
    input  ps2_key, io_n, io_out, io_dout,
    output ef_n, key_code, key_any, key_sel
  );
endinterface

// File: rtl/studio_keypad.sv
// Decodes PS/2 scancodes into one or two 10-key studio keypads and drives EF3/EF4.
// Optional debounce is enabled with macro STUDIO_KEYPAD_DEBOUNCE_EN.
module studio_keypad #(
  parameter int NUM_PADS   = 2,
  parameter int DEB_CYCLES = 50000
) (
  input logic              clk,
  input logic              resetq,
  studio_keypad_if.slave   kp
);

  localparam int unsigned NKEYS = 10;
  localparam int unsigned SELW  = 4;
  localparam int unsigned CODEW = 8;

  typedef logic [1:0][NKEYS-1:0] pads_t;

  if (NUM_PADS < 1 || NUM_PADS > 2) begin : g_bad_pads
    $error("studio_keypad: NUM_PADS must be 1..2");
  end
  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("studio_keypad: DEB_CYCLES must be 2..65535");
  end

  // {hit, key index} lookup for the main-row digits
  function automatic logic [4:0] map_pad0(input logic [7:0] sc);
    case (sc)
      8'h45: return {1'b1, 4'd0};
      8'h16: return {1'b1, 4'd1};
      8'h1E: return {1'b1, 4'd2};
      8'h26: return {1'b1, 4'd3};
      8'h25: return {1'b1, 4'd4};
      8'h2E: return {1'b1, 4'd5};
      8'h36: return {1'b1, 4'd6};
      8'h3D: return {1'b1, 4'd7};
      8'h3E: return {1'b1, 4'd8};
      8'h46: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // {hit, key index} lookup for the numeric keypad
  function automatic logic [4:0] map_pad1(input logic [7:0] sc);
    case (sc)
      8'h70: return {1'b1, 4'd0};
      8'h69: return {1'b1, 4'd1};
      8'h72: return {1'b1, 4'd2};
      8'h7A: return {1'b1, 4'd3};
      8'h6B: return {1'b1, 4'd4};
      8'h73: return {1'b1, 4'd5};
      8'h74: return {1'b1, 4'd6};
      8'h6C: return {1'b1, 4'd7};
      8'h75: return {1'b1, 4'd8};
      8'h7D: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  logic             valid_q, valid_d;
  logic             tog_q, tog_d;
  pads_t            raw_q, raw_d;
  pads_t            deb_c;
  logic [SELW-1:0]  key_sel_q, key_sel_d;
  logic [1:0]       ef_n_q, ef_n_d;
  logic [CODEW-1:0] key_code_q, key_code_d;
  logic             key_any_q, key_any_d;

  logic             evt_c;
  logic [4:0]       m0_c, m1_c;
  logic             sel_ok_c;
  logic [SELW-1:0]  sel_idx_c;
  logic             unused_dout;

  assign unused_dout = ^kp.io_dout[7:4];

  // Event capture, raw bitmap, select latch and registered outputs
  always_comb begin
    valid_d    = 1'b1;
    tog_d      = kp.ps2_key[10];
    raw_d      = raw_q;
    key_sel_d  = key_sel_q;
    ef_n_d     = 2'b11;
    key_code_d = 8'hFF;
    key_any_d  = 1'b0;

    evt_c = valid_q && (kp.ps2_key[10] != tog_q) && !kp.ps2_key[8];
    m0_c  = map_pad0(kp.ps2_key[7:0]);
    m1_c  = map_pad1(kp.ps2_key[7:0]);

    if (evt_c && m0_c[4]) raw_d[0][m0_c[3:0]] = kp.ps2_key[9];
    if (evt_c && m1_c[4] && (NUM_PADS > 1)) raw_d[1][m1_c[3:0]] = kp.ps2_key[9];

    if (kp.io_out && (kp.io_n == 3'd2)) key_sel_d = kp.io_dout[SELW-1:0];

    sel_ok_c  = (key_sel_q <= SELW'(9));
    sel_idx_c = sel_ok_c ? key_sel_q : '0;
    for (int p = 0; p < 2; p++) begin
      ef_n_d[p] = ~((p < NUM_PADS) && sel_ok_c && deb_c[p][sel_idx_c]);
    end

    for (int k = int'(NKEYS) - 1; k >= 0; k--) begin
      if (deb_c[0][k]) key_code_d = CODEW'(k);
    end
    key_any_d = (|deb_c[0]) || ((NUM_PADS > 1) && (|deb_c[1]));
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      valid_q    <= 1'b0;
      tog_q      <= 1'b0;
      raw_q      <= '0;
      key_sel_q  <= '0;
      ef_n_q     <= 2'b11;
      key_code_q <= 8'hFF;
      key_any_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      tog_q      <= tog_d;
      raw_q      <= raw_d;
      key_sel_q  <= key_sel_d;
      ef_n_q     <= ef_n_d;
      key_code_q <= key_code_d;
      key_any_q  <= key_any_d;
    end
  end

`ifdef STUDIO_KEYPAD_DEBOUNCE_EN
  localparam int unsigned PW = 16;

  logic [PW-1:0] presc_q, presc_d;
  pads_t         samp_q, samp_d;
  pads_t         deb_q, deb_d;
  logic          tick_c;
  pads_t         diff_c;

  // A key's debounced state follows raw only when two consecutive ticks agree
  always_comb begin
    tick_c  = (presc_q == PW'(DEB_CYCLES - 1));
    diff_c  = raw_q ^ samp_q;
    presc_d = tick_c ? '0 : presc_q + PW'(1);
    samp_d  = tick_c ? raw_q : samp_q;
    deb_d   = tick_c ? ((raw_q & ~diff_c) | (deb_q & diff_c)) : deb_q;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      presc_q <= '0;
      samp_q  <= '0;
      deb_q   <= '0;
    end else begin
      presc_q <= presc_d;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_c = deb_q;
`else
  assign deb_c = raw_q;
`endif

  assign kp.ef_n     = ef_n_q;
  assign kp.key_code = key_code_q;
  assign kp.key_any  = key_any_q;
  assign kp.key_sel  = key_sel_q;

endmodule

// File: tb/tb_studio_keypad.sv
// Directed bench for studio_keypad: a 2-pad and a 1-pad instance share one stimulus stream.
module tb_studio_keypad;

  localparam int DEB = 4;
`ifdef STUDIO_KEYPAD_DEBOUNCE_EN
  localparam int SETTLE = 2 * DEB + 3;
`else
  localparam int SETTLE = 2;
`endif

  logic        clk = 1'b0;
  logic        resetq;
  logic [10:0] ps2;
  logic        tog;
  logic [2:0]  io_n;
  logic        io_out;
  logic [7:0]  io_dout;
  int          checks = 0;
  int          failures = 0;
  int          lat;

  always #5 clk = ~clk;

  studio_keypad_if kp2 ();
  studio_keypad_if kp1 ();

  assign kp2.ps2_key = ps2;
  assign kp2.io_n    = io_n;
  assign kp2.io_out  = io_out;
  assign kp2.io_dout = io_dout;
  assign kp1.ps2_key = ps2;
  assign kp1.io_n    = io_n;
  assign kp1.io_out  = io_out;
  assign kp1.io_dout = io_dout;

  studio_keypad #(.NUM_PADS(2), .DEB_CYCLES(DEB)) dut2 (.clk(clk), .resetq(resetq), .kp(kp2));
  studio_keypad #(.NUM_PADS(1), .DEB_CYCLES(DEB)) dut1 (.clk(clk), .resetq(resetq), .kp(kp1));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] sc, input logic pr, input logic ext);
    tog = ~tog;
    ps2 = {tog, pr, ext, sc};
  endtask

  task automatic cpu_out(input logic [2:0] n, input logic [7:0] d);
    io_n    = n;
    io_dout = d;
    io_out  = 1'b1;
    tick(1);
    io_out  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetq  = 1'b0;
    tog     = 1'b0;
    ps2     = '0;
    io_n    = '0;
    io_out  = 1'b0;
    io_dout = '0;
    tick(3);
    chk("reset ef_n pad2", 8'(kp2.ef_n), 8'h03);
    chk("reset ef_n pad1", 8'(kp1.ef_n), 8'h03);
    chk("reset key_code", kp2.key_code, 8'hFF);
    chk("reset key_any", 8'(kp2.key_any), 8'h00);
    chk("reset key_sel", 8'(kp2.key_sel), 8'h00);
    resetq = 1'b1;
    tick(2);

    // select 5 and make 2E in the same cycle
    send(8'h2E, 1'b1, 1'b0);
    cpu_out(3'd2, 8'h05);
    chk("sel after out", 8'(kp2.key_sel), 8'h05);
`ifndef STUDIO_KEYPAD_DEBOUNCE_EN
    chk("ef_n one cycle after event", 8'(kp2.ef_n), 8'h03);
    tick(1);
`else
    tick(SETTLE);
`endif
    chk("ef_n key5 pad2", 8'(kp2.ef_n), 8'h02);
    chk("ef_n key5 pad1", 8'(kp1.ef_n), 8'h02);
    chk("key_code 5", kp2.key_code, 8'h05);
    send(8'h2E, 1'b0, 1'b0);
    tick(SETTLE);
    chk("ef_n after break 2E", 8'(kp2.ef_n), 8'h03);
    chk("key_any after break 2E", 8'(kp2.key_any), 8'h00);

    // lowest held key wins, typematic and stray breaks are harmless
    send(8'h3E, 1'b1, 1'b0); tick(SETTLE);
    chk("key_code 8", kp2.key_code, 8'h08);
    send(8'h16, 1'b1, 1'b0); tick(SETTLE);
    chk("key_code 1 over 8", kp2.key_code, 8'h01);
    send(8'h16, 1'b1, 1'b0); tick(SETTLE);
    chk("typematic 16", kp2.key_code, 8'h01);
    send(8'h3D, 1'b0, 1'b0); tick(SETTLE);
    chk("break unheld 3D", kp2.key_code, 8'h01);
    send(8'h16, 1'b0, 1'b0); tick(SETTLE);
    chk("key_code back to 8", kp2.key_code, 8'h08);
    send(8'h3E, 1'b0, 1'b0); tick(SETTLE);
    chk("key_code none", kp2.key_code, 8'hFF);
    chk("key_any none", 8'(kp2.key_any), 8'h00);

    // pad 1 key 6 on both pad counts
    send(8'h74, 1'b1, 1'b0); tick(SETTLE);
    cpu_out(3'd2, 8'h06);
    tick(1);
    chk("pad1 key6 ef_n 2pads", 8'(kp2.ef_n), 8'h01);
    chk("pad1 key6 ef_n 1pad", 8'(kp1.ef_n), 8'h03);
    chk("pad1 key_any 1pad", 8'(kp1.key_any), 8'h00);
    chk("pad1 key_any 2pads", 8'(kp2.key_any), 8'h01);
    chk("pad1 key_code", kp2.key_code, 8'hFF);
    send(8'h74, 1'b0, 1'b0); tick(SETTLE);
    chk("pad1 break ef_n", 8'(kp2.ef_n), 8'h03);

    // out-of-range select, extended events and non-select OUT ports
    send(8'h45, 1'b1, 1'b0); tick(SETTLE);
    cpu_out(3'd2, 8'h00);
    tick(1);
    chk("key0 selected", 8'(kp2.ef_n), 8'h02);
    cpu_out(3'd2, 8'h0C);
    tick(1);
    chk("sel 0C latched", 8'(kp2.key_sel), 8'h0C);
    chk("sel 0C ef_n", 8'(kp2.ef_n), 8'h03);
    chk("sel 0C key_code", kp2.key_code, 8'h00);
    send(8'h70, 1'b1, 1'b1); tick(SETTLE);
    cpu_out(3'd3, 8'h00);
    chk("io_n 3 ignored", 8'(kp2.key_sel), 8'h0C);
    cpu_out(3'd2, 8'h00);
    tick(1);
    chk("extended E0 70 ignored", 8'(kp2.ef_n), 8'h02);
    send(8'h45, 1'b0, 1'b0); tick(SETTLE);
    chk("key0 released", 8'(kp2.ef_n), 8'h03);

`ifdef STUDIO_KEYPAD_DEBOUNCE_EN
    // short glitch must not pass the debouncer; a stable press must, within the window
    cpu_out(3'd2, 8'h02);
    send(8'h1E, 1'b1, 1'b0); tick(1);
    send(8'h1E, 1'b0, 1'b0); tick(3 * DEB);
    chk("glitch filtered", 8'(kp2.ef_n), 8'h03);
    send(8'h1E, 1'b1, 1'b0); tick(1);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      if (lat == 0 && kp2.ef_n[0] == 1'b0) lat = n;
    end
    checks++;
    assert (lat >= 5 && lat <= 9) else begin
      failures++;
      $error("FAIL debounce latency observed=%0d expected=5..9", lat);
    end
    send(8'h1E, 1'b0, 1'b0); tick(SETTLE);
    chk("debounced release", 8'(kp2.ef_n), 8'h03);
`endif

    // async reset with a key held and key 7 selected
    send(8'h3D, 1'b1, 1'b0); tick(SETTLE);
    cpu_out(3'd2, 8'h07);
    tick(1);
    chk("key7 selected", 8'(kp2.ef_n), 8'h02);
    #2 resetq = 1'b0;
    #1;
    chk("async rst ef_n", 8'(kp2.ef_n), 8'h03);
    chk("async rst key_sel", 8'(kp2.key_sel), 8'h00);
    chk("async rst key_code", kp2.key_code, 8'hFF);
    tog = 1'b1;
    ps2 = {tog, 1'b1, 1'b0, 8'h3D};
    tick(2);
    resetq = 1'b1;
    tick(SETTLE + 2);
    chk("no event at reset release", 8'(kp2.key_any), 8'h00);
    chk("no key after reset", kp2.key_code, 8'hFF);
    send(8'h3D, 1'b0, 1'b0); tick(SETTLE);
    chk("break after reset", 8'(kp2.key_any), 8'h00);
    send(8'h3D, 1'b1, 1'b0); tick(SETTLE);
    chk("fresh make after reset", kp2.key_code, 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
